// File: rtl/mac_requant.sv
// int32 -> int8 requantizer: multiply, rounding right shift, zero-point add, saturate, output FIFO.
// Define REQUANT_ROUND_EN for round-half-up; otherwise the shift truncates toward -infinity.
module mac_requant #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SAT_CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 acc_valid_i,
    input  logic [31:0]          acc_data_i,
    output logic                 acc_ready_o,
    input  logic                 cfg_load_i,
    input  logic [15:0]          cfg_mult_i,
    input  logic [4:0]           cfg_shift_i,
    input  logic [7:0]           cfg_zp_i,
    output logic                 out_valid_o,
    output logic [7:0]           out_data_o,
    input  logic                 out_ready_i,
    output logic [SAT_CNT_W-1:0] sat_cnt_o,
    input  logic                 sat_clr_i,
    output logic                 busy_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = PTR_W + 2;

    logic [15:0]               mult_q, mult_d;
    logic [4:0]                shift_q, shift_d;
    logic [7:0]                zp_q, zp_d;

    logic                      v1_q, v1_d;
    logic signed [48:0]        p1_q, p1_d;
    logic [4:0]                sh1_q, sh1_d;
    logic [7:0]                zp1_q, zp1_d;

    logic                      v2_q, v2_d;
    logic signed [48:0]        q2_q, q2_d;
    logic [7:0]                zp2_q, zp2_d;

    logic                      v3_q, v3_d;
    logic [7:0]                y3_q, y3_d;
    logic                      sat3_q, sat3_d;

    logic [7:0]                mem_q [FIFO_DEPTH];
    logic [7:0]                mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [SAT_CNT_W-1:0]      sat_cnt_q, sat_cnt_d;

    logic                      accept;
    logic                      fifo_wr;
    logic                      fifo_rd;
    logic [OCC_W-1:0]          occupancy;
    logic signed [48:0]        prod_a;
    logic signed [48:0]        prod_m;
    logic signed [48:0]        rnd;
    logic signed [48:0]        r_sum;
    logic signed [49:0]        y_sum;

    // Counting in-flight items as occupied guarantees a FIFO slot for each, so the pipeline never stalls.
    assign occupancy   = OCC_W'(count_q) + OCC_W'(v1_q) + OCC_W'(v2_q) + OCC_W'(v3_q);
    assign acc_ready_o = occupancy < OCC_W'(FIFO_DEPTH);
    assign out_valid_o = count_q != '0;
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign sat_cnt_o   = sat_cnt_q;
    assign busy_o      = v1_q | v2_q | v3_q | out_valid_o;

    always_comb begin
        mult_d    = mult_q;
        shift_d   = shift_q;
        zp_d      = zp_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        sat_cnt_d = sat_cnt_q;

        accept = acc_valid_i && acc_ready_o;
        if (cfg_load_i) begin
            mult_d  = cfg_mult_i;
            shift_d = cfg_shift_i;
            zp_d    = cfg_zp_i;
        end

        // S1: items accepted on a cfg_load edge still see the previous config.
        prod_a = {{17{acc_data_i[31]}}, acc_data_i};
        prod_m = {33'd0, mult_q};
        v1_d   = accept;
        p1_d   = prod_a * prod_m;
        sh1_d  = shift_q;
        zp1_d  = zp_q;

        // S2
`ifdef REQUANT_ROUND_EN
        rnd = (sh1_q != 5'd0) ? (49'sd1 <<< (sh1_q - 5'd1)) : 49'sd0;
`else
        rnd = 49'sd0;
`endif
        r_sum = p1_q + rnd;
        v2_d  = v1_q;
        q2_d  = r_sum >>> sh1_q;
        zp2_d = zp1_q;

        // S3
        y_sum  = {q2_q[48], q2_q} + {{42{zp2_q[7]}}, zp2_q};
        v3_d   = v2_q;
        sat3_d = 1'b0;
        if (y_sum > 50'sd127) begin
            y3_d   = 8'h7f;
            sat3_d = 1'b1;
        end else if (y_sum < -50'sd128) begin
            y3_d   = 8'h80;
            sat3_d = 1'b1;
        end else begin
            y3_d   = y_sum[7:0];
        end

        fifo_wr = v3_q;
        fifo_rd = out_valid_o && out_ready_i;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = y3_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);

        if (sat_clr_i) begin
            sat_cnt_d = '0;
        end else if (v3_q && sat3_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mult_q    <= 16'd1;
            shift_q   <= '0;
            zp_q      <= '0;
            v1_q      <= 1'b0;
            p1_q      <= '0;
            sh1_q     <= '0;
            zp1_q     <= '0;
            v2_q      <= 1'b0;
            q2_q      <= '0;
            zp2_q     <= '0;
            v3_q      <= 1'b0;
            y3_q      <= '0;
            sat3_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sat_cnt_q <= '0;
        end else begin
            mult_q    <= mult_d;
            shift_q   <= shift_d;
            zp_q      <= zp_d;
            v1_q      <= v1_d;
            p1_q      <= p1_d;
            sh1_q     <= sh1_d;
            zp1_q     <= zp1_d;
            v2_q      <= v2_d;
            q2_q      <= q2_d;
            zp2_q     <= zp2_d;
            v3_q      <= v3_d;
            y3_q      <= y3_d;
            sat3_q    <= sat3_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// Self-checking bench for mac_requant: latency-queue reference model plus directed literal checks.
module tb_mac_requant;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          acc_valid_i;
    logic [31:0]   acc_data_i;
    logic          acc_ready_o;
    logic          cfg_load_i;
    logic [15:0]   cfg_mult_i;
    logic [4:0]    cfg_shift_i;
    logic [7:0]    cfg_zp_i;
    logic          out_valid_o;
    logic [7:0]    out_data_o;
    logic          out_ready_i;
    logic [SW-1:0] sat_cnt_o;
    logic          sat_clr_i;
    logic          busy_o;

    always #5 clk = ~clk;

    mac_requant #(.FIFO_DEPTH(DEPTH), .SAT_CNT_W(SW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .acc_valid_i (acc_valid_i),
        .acc_data_i  (acc_data_i),
        .acc_ready_o (acc_ready_o),
        .cfg_load_i  (cfg_load_i),
        .cfg_mult_i  (cfg_mult_i),
        .cfg_shift_i (cfg_shift_i),
        .cfg_zp_i    (cfg_zp_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .sat_cnt_o   (sat_cnt_o),
        .sat_clr_i   (sat_clr_i),
        .busy_o      (busy_o)
    );

    typedef struct {
        logic [7:0] val;
        bit         sat;
        int         age;
    } item_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    item_t       pipe[$];
    logic [7:0]  fifo[$];
    logic [7:0]  obs[$];
    int unsigned m_sat;
    int unsigned m_mult;
    int unsigned m_shift;
    int          m_zp;
    bit          last_accept;

    // Expected {sat, int8} straight from the arithmetic definition.
    function automatic logic [8:0] requant(int acc, int unsigned mult, int unsigned shift, int zp);
        longint p;
        p = longint'(acc) * longint'(mult);
`ifdef REQUANT_ROUND_EN
        if (shift > 0) p = p + (longint'(1) << (shift - 1));
`endif
        p = p >>> shift;
        p = p + longint'(zp);
        if (p > 127)  return {1'b1, 8'h7f};
        if (p < -128) return {1'b1, 8'h80};
        return {1'b0, 8'(p)};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        fifo.delete();
        m_sat   = 0;
        m_mult  = 1;
        m_shift = 0;
        m_zp    = 0;
    endtask

    task automatic compare_outputs();
        bit exp_valid;
        exp_valid = fifo.size() > 0;
        chk("out_valid", longint'(out_valid_o), longint'(exp_valid));
        if (exp_valid) chk("out_data", longint'($signed(out_data_o)), longint'($signed(fifo[0])));
        chk("acc_ready", longint'(acc_ready_o), longint'((fifo.size() + pipe.size()) < DEPTH));
        chk("busy", longint'(busy_o), longint'((fifo.size() + pipe.size()) > 0));
        chk("sat_cnt", longint'(sat_cnt_o), longint'(m_sat));
    endtask

    // One clock: check state left by the previous edge, drive inputs, advance the model across the next edge.
    task automatic step(input bit v, input int data, input bit ordy, input bit ld,
                        input int unsigned mult, input int unsigned shift, input int zp, input bit clr);
        logic [8:0] r;
        item_t      it;
        bit         acc;
        @(negedge clk);
        compare_outputs();
        acc_valid_i = v;
        acc_data_i  = data;
        out_ready_i = ordy;
        cfg_load_i  = ld;
        cfg_mult_i  = 16'(mult);
        cfg_shift_i = 5'(shift);
        cfg_zp_i    = 8'(zp);
        sat_clr_i   = clr;
        if (out_valid_o && ordy) obs.push_back(out_data_o);

        acc = v && ((fifo.size() + pipe.size()) < DEPTH);
        last_accept = acc;
        if (fifo.size() > 0 && ordy) void'(fifo.pop_front());
        if (pipe.size() > 0 && pipe[0].age == 3) begin
            it = pipe.pop_front();
            fifo.push_back(it.val);
            if (it.sat && m_sat != (2**SW - 1)) m_sat++;
        end
        for (int i = 0; i < pipe.size(); i++) pipe[i].age = pipe[i].age + 1;
        if (clr) m_sat = 0;
        if (acc) begin
            r = requant(data, m_mult, m_shift, m_zp);
            pipe.push_back('{val: r[7:0], sat: r[8], age: 1});
        end
        if (ld) begin
            m_mult  = mult;
            m_shift = shift;
            m_zp    = zp;
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 0, ordy, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic load_cfg(input int unsigned mult, input int unsigned shift, input int zp);
        step(1'b0, 0, 1'b1, 1'b1, mult, shift, zp, 1'b0);
    endtask

    task automatic send(input int data, input bit ordy);
        step(1'b1, data, ordy, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fifo.size() + pipe.size()) > 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        if ((fifo.size() + pipe.size()) > 0) chk("drain_timeout", 1, 0);
    endtask

    task automatic chk_obs(input string name, input int idx, input int exp);
        if (obs.size() > idx) chk(name, longint'($signed(obs[idx])), longint'(exp));
        else chk({name, "_missing"}, longint'(obs.size()), longint'(idx + 1));
    endtask

    initial begin
        int idx;
        int n;
        rst = 1'b1;
        acc_valid_i = 1'b0; acc_data_i = '0; out_ready_i = 1'b0; cfg_load_i = 1'b0;
        cfg_mult_i = '0; cfg_shift_i = '0; cfg_zp_i = '0; sat_clr_i = 1'b0;
        model_reset();
        #12;
        chk("rst_acc_ready", longint'(acc_ready_o), 1);
        chk("rst_out_valid", longint'(out_valid_o), 0);
        chk("rst_out_data", longint'(out_data_o), 0);
        chk("rst_sat_cnt", longint'(sat_cnt_o), 0);
        chk("rst_busy", longint'(busy_o), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);

        // Scaling and latency.
        load_cfg(16384, 15, -5);
        obs.delete();
        send(200, 1'b0);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk("latency_not_early", longint'(out_valid_o), 0);
        idle(1'b1);
        chk("scale_count", longint'(obs.size()), 1);
        chk_obs("scale_value", 0, 95);
        chk("scale_sat_cnt", longint'(sat_cnt_o), 0);
        drain();

        // Saturation and counter clear.
        load_cfg(16384, 15, 0);
        obs.delete();
        send(1000, 1'b1);
        send(-1000, 1'b1);
        drain();
        chk_obs("sat_pos", 0, 127);
        chk_obs("sat_neg", 1, -128);
        chk("sat_cnt_two", longint'(sat_cnt_o), 2);
        step(1'b0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        idle(1'b1);
        chk("sat_cnt_clr", longint'(sat_cnt_o), 0);

        // Rounding mode.
        load_cfg(1, 1, 0);
        obs.delete();
        send(3, 1'b1);
        send(-3, 1'b1);
        drain();
`ifdef REQUANT_ROUND_EN
        chk_obs("round_pos", 0, 2);
        chk_obs("round_neg", 1, -1);
`else
        chk_obs("round_pos", 0, 1);
        chk_obs("round_neg", 1, -2);
`endif

        // Config change between back-to-back items.
        load_cfg(16384, 15, 0);
        obs.delete();
        step(1'b1, 200, 1'b1, 1'b1, 16384, 14, 0, 1'b0);
        send(200, 1'b1);
        drain();
        chk_obs("cfg_switch_first", 0, 100);
        chk_obs("cfg_switch_second", 1, 127);
        chk("cfg_switch_sat", longint'(sat_cnt_o), 1);

        // Backpressure.
        load_cfg(1, 0, 0);
        obs.delete();
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step(idx < 8, idx + 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
            if (last_accept) idx++;
        end
        chk("bp_accepted", longint'(idx), longint'(DEPTH));
        chk("bp_ready_low", longint'(acc_ready_o), 0);
        n = 0;
        while ((idx < 8 || (fifo.size() + pipe.size()) > 0) && n < 60) begin
            step(idx < 8, idx + 1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
            if (last_accept) idx++;
            n++;
        end
        chk("bp_all_accepted", longint'(idx), 8);
        chk("bp_obs_count", longint'(obs.size()), 8);
        for (int i = 0; i < 8; i++) chk_obs("bp_order", i, i + 1);

        // Reset with three items in flight.
        load_cfg(16384, 15, 0);
        send(1000, 1'b0);
        send(200, 1'b0);
        send(-1000, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", longint'(busy_o), 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(out_valid_o), 0);
        chk("midrst_sat_cnt", longint'(sat_cnt_o), 0);
        chk("midrst_acc_ready", longint'(acc_ready_o), 1);
        chk("midrst_busy", longint'(busy_o), 0);
        model_reset();
        @(negedge clk);
        acc_valid_i = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) idle(1'b1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bit          v, ordy, ld, clr;
            int          data;
            int unsigned mult, shift;
            int          zp;
            v     = $urandom_range(0, 3) != 0;
            data  = ($urandom_range(0, 3) == 0) ? int'($urandom()) : int'($urandom_range(0, 400000)) - 200000;
            ordy  = $urandom_range(0, 3) != 0;
            ld    = $urandom_range(0, 31) == 0;
            mult  = $urandom_range(0, 65535);
            shift = $urandom_range(0, 31);
            zp    = int'($urandom_range(0, 255)) - 128;
            clr   = $urandom_range(0, 63) == 0;
            step(v, data, ordy, ld, mult, shift, zp, clr);
        end
        drain();
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
